x2050_seq_adder: RTL and testbench

- Multi-cycle, parametrised binary/packed-decimal adder for the 2050 datapath.
- Processes SLICE_DIGITS 4-bit digits per clock, LSB first, with a registered carry between slices.
- Supports decimal add/subtract with per-digit +6 correction, binary add/subtract, and a start/busy/done handshake.
- Sits beside the main combinational adder and serves long decimal operands (WIDTH up to 64+) without a long carry chain.

---
 rtl/x2050_seq_adder.sv | 177 +++++++++++++++++
 tb/tb_x2050_seq_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/x2050_seq_adder.sv
// Multi-cycle binary / packed-decimal adder: SLICE_DIGITS digits per clock, LSB slice first.
// Define X2050_SEQ_EARLY_EXIT_EN to finish as soon as the remaining operand slices and carry are zero.
module x2050_seq_adder #(
    parameter int WIDTH        = 32,
    parameter int SLICE_DIGITS = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_dec,
    input  logic             i_sub,
    input  logic             i_carry_in,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_dec_invalid
);

    localparam int SB     = 4 * SLICE_DIGITS;
    localparam int STEPS  = WIDTH / SB;
    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]    step_q, step_d;
    logic             carry_q, carry_d, dec_q, dec_d, inv_q, inv_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, dinv_q, dinv_d;

    logic [WIDTH-1:0] b_cpl, next_acc, final_sum;
    logic             start_inv;
    logic [SB-1:0]    slice_a, slice_b, slice_sum, dec_sum;
    logic [SB:0]      bin_full;
    logic             dec_c, slice_cout, msb_cin, last_step, early_exit;
    logic [4:0]       dec_s;
    int               sh;

    // Operand conditioning at start: complement B and flag non-BCD digits of the raw inputs.
    always_comb begin
        b_cpl     = i_dec ? '0 : (i_sub ? ~i_b : i_b);
        start_inv = 1'b0;
        if (i_dec) begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
                b_cpl[4*d +: 4] = i_sub ? (4'd9 - i_b[4*d +: 4]) : i_b[4*d +: 4];
                start_inv       = start_inv | (i_a[4*d +: 4] > 4'd9) | (i_b[4*d +: 4] > 4'd9);
            end
        end
    end

    always_comb begin
        slice_a  = a_q[SB-1:0];
        slice_b  = b_q[SB-1:0];
        bin_full = {1'b0, slice_a} + {1'b0, slice_b} + {{SB{1'b0}}, carry_q};
        msb_cin  = slice_a[SB-1] ^ slice_b[SB-1] ^ bin_full[SB-1];
        dec_sum  = '0;
        dec_c    = carry_q;
        dec_s    = '0;
        for (int unsigned d = 0; d < SLICE_DIGITS; d++) begin
            dec_s = {1'b0, slice_a[4*d +: 4]} + {1'b0, slice_b[4*d +: 4]} + {4'd0, dec_c};
            if (dec_s > 5'd9) begin
                dec_sum[4*d +: 4] = dec_s[3:0] + 4'd6;
                dec_c             = 1'b1;
            end else begin
                dec_sum[4*d +: 4] = dec_s[3:0];
                dec_c             = 1'b0;
            end
        end
        slice_sum  = dec_q ? dec_sum : bin_full[SB-1:0];
        slice_cout = dec_q ? dec_c : bin_full[SB];
        last_step  = (step_q == CW'(STEPS - 1));
`ifdef X2050_SEQ_EARLY_EXIT_EN
        early_exit = !last_step && !slice_cout && ((a_q >> SB) == '0) && ((b_q >> SB) == '0);
`else
        early_exit = 1'b0;
`endif
        // Slices enter at the top of the accumulator; an early finish shifts them down into place.
        next_acc  = (acc_q >> SB) | (WIDTH'(slice_sum) << (WIDTH - SB));
        sh        = SB * (STEPS - 1 - int'(step_q));
        final_sum = next_acc >> sh;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        carry_d = carry_q;
        dec_d   = dec_q;
        inv_d   = inv_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        dinv_d  = dinv_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = b_cpl;
                    dec_d   = i_dec;
                    carry_d = i_carry_in;
                    inv_d   = start_inv;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> SB;
                b_d     = b_q >> SB;
                carry_d = slice_cout;
                acc_d   = next_acc;
                step_d  = step_q + CW'(1);
                if (last_step || early_exit) begin
                    state_d = S_DONE;
                    sum_d   = final_sum;
                    zero_d  = (final_sum == '0);
                    cout_d  = slice_cout;
                    ovf_d   = !dec_q && !early_exit && (msb_cin ^ slice_cout);
                    dinv_d  = inv_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            carry_q <= 1'b0;
            dec_q   <= 1'b0;
            inv_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            dinv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            carry_q <= carry_d;
            dec_q   <= dec_d;
            inv_q   <= inv_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            dinv_q  <= dinv_d;
        end
    end

    assign o_busy        = (state_q == S_RUN);
    assign o_done        = (state_q == S_DONE);
    assign o_sum         = sum_q;
    assign o_carry       = cout_q;
    assign o_overflow    = ovf_q;
    assign o_zero        = zero_q;
    assign o_dec_invalid = dinv_q;

endmodule

// File: tb/tb_x2050_seq_adder.sv
// Scoreboard bench for x2050_seq_adder (WIDTH=32, SLICE_DIGITS=2); honours X2050_SEQ_EARLY_EXIT_EN.
`timescale 1ns/1ps
module tb_x2050_seq_adder;

    logic        clk = 1'b0;
    logic        rst, start, dec, sub, cin;
    logic [31:0] a, b;
    logic        busy, done, carry, ovf, zero, dinv;
    logic [31:0] sum;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] sum;
        logic        carry, ovf, zero, inv;
        int          lat;
        time         t0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_sum = '0;

    x2050_seq_adder #(.WIDTH(32), .SLICE_DIGITS(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_dec(dec), .i_sub(sub),
        .i_carry_in(cin), .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
        .o_sum(sum), .o_carry(carry), .o_overflow(ovf), .o_zero(zero),
        .o_dec_invalid(dinv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits use the digit-serial +6 rule on integers, binary uses wide arithmetic.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic dm, input logic sm, input logic ci);
        exp_t        e;
        logic [31:0] bb, s32;
        logic [32:0] full;
        int          c, s, ad, bd, slc[4];
        longint      m;
        e.inv = 1'b0;
        e.ovf = 1'b0;
        bb    = '0;
        s32   = '0;
        if (dm) begin
            c = int'(ci);
            for (int d = 0; d < 8; d++) begin
                ad = int'(av[4*d +: 4]);
                bd = int'(bv[4*d +: 4]);
                if (ad > 9 || bd > 9) e.inv = 1'b1;
                if (sm) bd = (9 - bd) & 15;
                bb[4*d +: 4] = 4'(bd);
                s = ad + bd + c;
                if (s > 9) begin
                    s32[4*d +: 4] = 4'((s + 6) % 16);
                    c = 1;
                end else begin
                    s32[4*d +: 4] = 4'(s);
                    c = 0;
                end
                if (d % 2 == 1) slc[d/2] = c;
            end
            e.carry = (c != 0);
        end else begin
            bb      = sm ? ~bv : bv;
            full    = {1'b0, av} + {1'b0, bb} + 33'(ci);
            s32     = full[31:0];
            e.carry = full[32];
            e.ovf   = (av[31] == bb[31]) && (s32[31] != av[31]);
            for (int k = 0; k < 4; k++) begin
                m      = (64'sd1 <<< (8 * (k + 1))) - 1;
                slc[k] = int'((((longint'(av) & m) + (longint'(bb) & m) + longint'(ci)) >>> (8 * (k + 1))) & 1);
            end
        end
        e.lat = 4;
`ifdef X2050_SEQ_EARLY_EXIT_EN
        for (int k = 0; k < 3; k++) begin
            if (e.lat == 4 && (av >> (8 * (k + 1))) == 0 && (bb >> (8 * (k + 1))) == 0 && slc[k] == 0) begin
                e.lat   = k + 1;
                e.carry = 1'b0;
                e.ovf   = 1'b0;
            end
        end
`endif
        e.sum  = s32;
        e.zero = (s32 == 0);
        e.t0   = 0;
        return e;
    endfunction

    // Monitor: every o_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got o_done=1, expected no pending operation at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", sum, e.sum);
                chk("carry", 32'(carry), 32'(e.carry));
                chk("overflow", 32'(ovf), 32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
                chk("dec_invalid", 32'(dinv), 32'(e.inv));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("latency", 32'(($time - e.t0 - 5) / 10), 32'(e.lat));
                last_sum = e.sum;
            end
        end
    end

    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic dm,
                         input logic sm, input logic ci, input bit expect_done);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; dec = dm; sub = sm; cin = ci; start = 1'b1;
        e = model(av, bv, dm, sm, ci);
        @(posedge clk);
        e.t0 = $time;
        if (expect_done) sb.push_back(e);
        #1 start = 1'b0;
        chk("sum_held_at_start", sum, last_sum);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !busy && !done) ok = 1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"}, sum, 32'd0);
        chk({tag, "_flags"}, {28'd0, carry, ovf, zero, dinv}, 32'd0);
    endtask

    function automatic logic [31:0] rand_bcd();
        logic [31:0] v = '0;
        for (int d = 0; d < 8; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; dec = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'h0000_9999, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'h0000_0050, 32'h0000_0075, 1'b1, 1'b1, 1'b1, 1); wait_idle();
        do_op(32'h0000_0075, 32'h0000_0050, 1'b1, 1'b1, 1'b1, 1); wait_idle();
        do_op(32'h0000_000A, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1); wait_idle();
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1); wait_idle();

        // A second start while running must be ignored.
        do_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (6) @(posedge clk);

        // Reset asserted at the second edge after start aborts the operation.
        do_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_all_zero("midreset");
        @(negedge clk) rst = 1'b0;
        last_sum = '0;
        repeat (8) @(posedge clk);
        do_op(32'h0012_3456, 32'h0065_4321, 1'b1, 1'b0, 1'b0, 1); wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra, rb;
            logic        rd;
            int          kind;
            rd   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            ra   = rd ? rand_bcd() : $urandom();
            rb   = rd ? rand_bcd() : $urandom();
            if (kind == 0) begin
                ra = $urandom();
                rb = $urandom();
            end else if (kind == 1) begin
                ra = ra & 32'h0000_00FF;
                rb = rb & 32'h0000_00FF;
            end else if (kind == 2) begin
                ra = ra & 32'h0000_FFFF;
                rb = rb & 32'h0000_0FFF;
            end
            do_op(ra, rb, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            if ($urandom_range(0, 3) == 0) wait_idle();
            else begin
                repeat (3) @(posedge clk);
                wait_idle();
            end
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion, expected finish before 2 ms");
        $fatal(1, "simulation time limit");
    end

endmodule
